// File: rtl/hsadc_pkg.sv
// Shared definitions for the high-speed ADC sample packetizer and its host-side decoder model.
// Packet layout: sync, sequence, count, 2*count sample bytes (MSB first), XOR checksum.
package hsadc_pkg;

   localparam int HSADC_SAMPLE_WIDTH = 16;
   localparam logic [7:0] HSADC_SYNC_BYTE = 8'hA5;

   // Header byte offsets within a packet, shared with the host-side decoder.
   localparam int HSADC_OFS_SYNC  = 0;
   localparam int HSADC_OFS_SEQ   = 1;
   localparam int HSADC_OFS_CNT   = 2;
   localparam int HSADC_OFS_DATA  = 3;
   localparam int HSADC_HDR_BYTES = 3;

   // Each state names the next byte to be loaded into the output register.
   // The sync byte is loaded on the way out of IDLE or DONE, so a new packet can follow tlast directly.
   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SEQ,
      ST_CNT,
      ST_HI,
      ST_LO,
      ST_SUM,
      ST_DONE
   } hsadc_state_e;

   function automatic int hsadc_packet_bytes(input int samples);
      return HSADC_HDR_BYTES + 2 * samples + 1;
   endfunction

endpackage

// File: rtl/hsadc_sample_packetizer.sv
// Frames 16-bit ADC samples into byte packets for the USB FIFO stream.
// The output byte register is the only buffer; backpressure reaches the ADC through s_axis_tready.
module hsadc_sample_packetizer
   import hsadc_pkg::*;
#(
   parameter int         SAMPLES_PER_PACKET = 32,
   parameter logic [7:0] SYNC_BYTE          = HSADC_SYNC_BYTE
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [HSADC_SAMPLE_WIDTH-1:0] s_axis_tdata,
   input  logic                          s_axis_tvalid,
   output logic                          s_axis_tready,
   output logic [7:0]                    m_axis_tdata,
   output logic                          m_axis_tvalid,
   input  logic                          m_axis_tready,
   output logic                          m_axis_tlast
);

   localparam logic [7:0] COUNT_BYTE = 8'(SAMPLES_PER_PACKET);

   hsadc_state_e state;
   logic [7:0]   sequence_num;
   logic [7:0]   checksum;
   logic [7:0]   sample_count;
   logic [7:0]   low_hold;
   logic         out_free;

   assign out_free      = !m_axis_tvalid || m_axis_tready;
   assign s_axis_tready = (state == ST_HI) && out_free;

   // NOTE: all state and output flops use non-blocking assignments and the asynchronous active-low
   // reset; a byte register that is not reloaded simply keeps its value, so no else-branches are needed.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state         <= ST_IDLE;
         m_axis_tdata  <= 8'h00;
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         sequence_num  <= 8'h00;
         checksum      <= 8'h00;
         sample_count  <= 8'h00;
         low_hold      <= 8'h00;
      end else if (out_free) begin
         // Output slot is free: a byte is loaded below, or tvalid falls for one idle slot.
         m_axis_tvalid <= 1'b0;
         m_axis_tlast  <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (s_axis_tvalid) begin
                  m_axis_tdata  <= SYNC_BYTE;
                  m_axis_tvalid <= 1'b1;
                  checksum      <= 8'h00;
                  state         <= ST_SEQ;
               end
            end
            ST_SEQ: begin
               m_axis_tdata  <= sequence_num;
               m_axis_tvalid <= 1'b1;
               checksum      <= sequence_num;
               state         <= ST_CNT;
            end
            ST_CNT: begin
               m_axis_tdata  <= COUNT_BYTE;
               m_axis_tvalid <= 1'b1;
               checksum      <= checksum ^ COUNT_BYTE;
               state         <= ST_HI;
            end
            ST_HI: begin
               if (s_axis_tvalid) begin
                  m_axis_tdata  <= s_axis_tdata[15:8];
                  m_axis_tvalid <= 1'b1;
                  low_hold      <= s_axis_tdata[7:0];
                  checksum      <= checksum ^ s_axis_tdata[15:8] ^ s_axis_tdata[7:0];
                  sample_count  <= sample_count + 8'd1;
                  state         <= ST_LO;
               end
            end
            ST_LO: begin
               m_axis_tdata  <= low_hold;
               m_axis_tvalid <= 1'b1;
               state         <= (sample_count < COUNT_BYTE) ? ST_HI : ST_SUM;
            end
            ST_SUM: begin
               m_axis_tdata  <= checksum;
               m_axis_tvalid <= 1'b1;
               m_axis_tlast  <= 1'b1;
               state         <= ST_DONE;
            end
            ST_DONE: begin
               // The checksum byte is held here, so out_free means it was just accepted.
               sequence_num <= sequence_num + 8'd1;
               sample_count <= 8'h00;
               if (s_axis_tvalid) begin
                  m_axis_tdata  <= SYNC_BYTE;
                  m_axis_tvalid <= 1'b1;
                  checksum      <= 8'h00;
                  state         <= ST_SEQ;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_hsadc_sample_packetizer.sv
// Scoreboard bench for hsadc_sample_packetizer with four samples per packet.
// Expected packet bytes are queued as samples are driven and compared as the DUT emits them.
module tb_hsadc_sample_packetizer;
   import hsadc_pkg::*;

   localparam int SPP = 4;

   typedef struct {
      logic [7:0] data;
      logic       last;
      bit         contig;
      int         due;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] s_axis_tdata;
   logic        s_axis_tvalid;
   logic        s_axis_tready;
   logic [7:0]  m_axis_tdata;
   logic        m_axis_tvalid;
   logic        m_axis_tready;
   logic        m_axis_tlast;

   always #5 clk = ~clk;

   hsadc_sample_packetizer #(.SAMPLES_PER_PACKET(SPP)) dut (
      .clk           (clk),
      .rst           (rst),
      .s_axis_tdata  (s_axis_tdata),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tready (s_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tlast  (m_axis_tlast)
   );

   exp_t       sb_q[$];
   int         vectors     = 0;
   int         miscompares = 0;
   int         cyc         = 0;
   bit         rand_ready  = 1'b0;
   bit         sb_off      = 1'b0;
   logic [7:0] seq_m       = 8'h00;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_exp(input logic [7:0] data, input logic last, input bit contig, input int due);
      exp_t e;
      e.data   = data;
      e.last   = last;
      e.contig = contig;
      e.due    = due;
      sb_q.push_back(e);
   endtask

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         m_axis_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   end

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish, queue depth %0d", sb_q.size());
      $fatal(1, "watchdog expired");
   end

   // Monitor: compares accepted bytes with the scoreboard and checks stall behaviour.
   initial begin : monitor
      exp_t       e;
      logic [7:0] held_data;
      logic       held_last;
      bit         stalled;
      int         last_cyc;
      stalled  = 1'b0;
      last_cyc = -10;
      forever begin
         @(negedge clk);
         if (!rst) begin
            stalled = 1'b0;
            continue;
         end
         if (m_axis_tvalid && !m_axis_tready) begin
            check("s_ready_while_stalled", s_axis_tready, 0);
            if (stalled) begin
               check("stall_hold_data", m_axis_tdata, held_data);
               check("stall_hold_last", m_axis_tlast, held_last);
            end
            stalled   = 1'b1;
            held_data = m_axis_tdata;
            held_last = m_axis_tlast;
         end else begin
            stalled = 1'b0;
         end
         if (m_axis_tvalid && m_axis_tready) begin
            if (!sb_off) begin
               if (sb_q.size() == 0) begin
                  check("unexpected_byte", {24'h0, m_axis_tdata}, 32'hFFFF_FFFF);
               end else begin
                  e = sb_q.pop_front();
                  check("byte_data", m_axis_tdata, e.data);
                  check("byte_last", m_axis_tlast, e.last);
                  if (e.contig) check("byte_gap", cyc - last_cyc, 1);
                  if (e.due >= 0) check("sync_latency", cyc, e.due);
               end
            end
            last_cyc = cyc;
         end
      end
   end

   // All driver tasks start and end one time unit after a rising edge.
   task automatic wait_accept();
      bit hs;
      int n;
      hs = 1'b0;
      n  = 0;
      while (!hs && n < 300) begin
         @(negedge clk);
         hs = s_axis_tready;
         @(posedge clk);
         #1;
         n++;
      end
      if (!hs) check("accept_timeout", 0, 1);
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < 5000) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_timeout", sb_q.size(), 0);
   endtask

   task automatic send_packet(input logic [15:0] smp[SPP], input bit contig_first, input bit contig_rest,
                              input bit timed, input int gap_after, input int gap_len);
      logic [7:0] cs;
      cs = seq_m ^ 8'(SPP);
      push_exp(HSADC_SYNC_BYTE, 1'b0, contig_first, timed ? cyc + 1 : -1);
      push_exp(seq_m, 1'b0, contig_rest, -1);
      push_exp(8'(SPP), 1'b0, contig_rest, -1);
      for (int i = 0; i < SPP; i++) begin
         push_exp(smp[i][15:8], 1'b0, contig_rest, -1);
         push_exp(smp[i][7:0], 1'b0, contig_rest, -1);
         cs = cs ^ smp[i][15:8] ^ smp[i][7:0];
      end
      push_exp(cs, 1'b1, contig_rest, -1);
      seq_m = seq_m + 8'd1;
      for (int i = 0; i < SPP; i++) begin
         s_axis_tdata  = smp[i];
         s_axis_tvalid = 1'b1;
         wait_accept();
         s_axis_tvalid = 1'b0;
         if (i == gap_after) begin
            for (int g = 0; g < gap_len; g++) begin
               @(negedge clk);
               if (g >= 2) check("gap_tvalid", m_axis_tvalid, 0);
               @(posedge clk);
               #1;
            end
         end
      end
   endtask

   initial begin
      logic [15:0] smp [SPP];
      logic [15:0] smp_b [SPP];
      rst           = 1'b0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata  = 16'h0000;
      repeat (3) @(posedge clk);
      #1;
      check("reset_tvalid", m_axis_tvalid, 0);
      check("reset_tdata", m_axis_tdata, 0);
      check("reset_tlast", m_axis_tlast, 0);
      check("reset_s_tready", s_axis_tready, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      // Basic packet: timed sync, then eleven back-to-back bytes ending in checksum 0C.
      smp = '{16'h0102, 16'h0304, 16'h0506, 16'h0708};
      send_packet(smp, 1'b0, 1'b1, 1'b1, -1, 0);
      wait_drain();

      // Two packets fed continuously: the second sync directly follows the first tlast.
      smp_b = '{16'h1122, 16'h3344, 16'h5566, 16'h7788};
      send_packet(smp, 1'b0, 1'b1, 1'b0, -1, 0);
      send_packet(smp_b, 1'b1, 1'b1, 1'b0, -1, 0);
      wait_drain();

      // Random downstream backpressure.
      rand_ready = 1'b1;
      send_packet(smp, 1'b0, 1'b0, 1'b0, -1, 0);
      send_packet(smp_b, 1'b0, 1'b0, 1'b0, -1, 0);
      wait_drain();
      rand_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;

      // Ten-cycle sample gap after the second sample.
      send_packet(smp, 1'b0, 1'b0, 1'b0, 1, 10);
      wait_drain();

      // Long run so the sequence byte wraps FF -> 00 -> 01.
      for (int p = 0; p < 257; p++) begin
         for (int j = 0; j < SPP; j++) smp_b[j] = 16'($urandom);
         send_packet(smp_b, (p != 0), 1'b1, 1'b0, -1, 0);
      end
      wait_drain();

      // Asynchronous reset while a sample byte is on the output.
      sb_off        = 1'b1;
      s_axis_tdata  = 16'h1111;
      s_axis_tvalid = 1'b1;
      wait_accept();
      @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      check("abort_tvalid", m_axis_tvalid, 0);
      check("abort_tdata", m_axis_tdata, 0);
      check("abort_tlast", m_axis_tlast, 0);
      check("abort_s_tready", s_axis_tready, 0);
      s_axis_tvalid = 1'b0;
      sb_q.delete();
      seq_m  = 8'h00;
      sb_off = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      send_packet(smp, 1'b0, 1'b1, 1'b1, -1, 0);
      wait_drain();

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
